// File: rtl/hsv_core_commit_if.sv
// Result handshake from one execution unit into the commit stage.
interface hsv_commit_unit_if #(
   parameter int unsigned XLEN     = 32,
   parameter int unsigned NUM_REGS = 32
);
   localparam int unsigned RW = $clog2(NUM_REGS);

   logic            valid_i;
   logic            ready_o;
   logic [RW-1:0]   rd;
   logic            rd_we;
   logic [XLEN-1:0] result;
   logic            trap;
   logic [XLEN-1:0] pc;

   modport master (output valid_i, rd, rd_we, result, trap, pc, input ready_o);
   modport slave  (input valid_i, rd, rd_we, result, trap, pc, output ready_o);
endinterface

// File: rtl/hsv_core_commit.sv
// HSV commit stage: round-robin pick of one execution-unit result per cycle,
// register-file writeback, hazard-bit clear mask and trap reporting.
module hsv_core_commit #(
   parameter int unsigned XLEN     = 32,
   parameter int unsigned NUM_REGS = 32
) (
   input  logic                        clk_core,
   input  logic                        rst_core_n,
   input  logic                        flush_req,
   output logic                        flush_ack,
   hsv_commit_unit_if.slave            alu,
   hsv_commit_unit_if.slave            branch,
   hsv_commit_unit_if.slave            ctrl_status,
   hsv_commit_unit_if.slave            mem,
   output logic [$clog2(NUM_REGS)-1:0] wr_addr,
   output logic [XLEN-1:0]             wr_data,
   output logic                        wr_en,
   output logic [NUM_REGS-1:0]         commit_mask,
   output logic                        trap_o,
   output logic [XLEN-1:0]             trap_pc_o,
   output logic [63:0]                 retired_count
);
   localparam int unsigned RW        = $clog2(NUM_REGS);
   localparam int unsigned NUM_UNITS = 4;
   localparam int unsigned UW        = 2;

   typedef enum logic {RUN, TRAPPED} state_t;

   state_t               state_q;
   state_t               state_d;
   logic [UW-1:0]        last_grant;
   logic [UW-1:0]        grant_idx;
   logic [UW-1:0]        cand;
   logic                 grant_any;
   logic                 accept;
   logic                 take;
   logic [NUM_UNITS-1:0] valid_vec;
   logic [NUM_UNITS-1:0] ready_vec;
   logic [RW-1:0]        sel_rd;
   logic                 sel_we;
   logic                 sel_trap;
   logic [XLEN-1:0]      sel_result;
   logic [XLEN-1:0]      sel_pc;
   logic                 sel_wb;

   assign valid_vec = {mem.valid_i, ctrl_status.valid_i, branch.valid_i, alu.valid_i};

   assign alu.ready_o         = ready_vec[0];
   assign branch.ready_o      = ready_vec[1];
   assign ctrl_status.ready_o = ready_vec[2];
   assign mem.ready_o         = ready_vec[3];

   // State register
   always_ff @(posedge clk_core or negedge rst_core_n) begin
      if (!rst_core_n) state_q <= RUN;
      else             state_q <= state_d;
   end

   // Arbitration, handshake and next state
   always_comb begin
      state_d   = state_q;
      grant_idx = '0;
      grant_any = 1'b0;
      cand      = '0;
      accept    = 1'b0;
      ready_vec = '0;
      for (int i = 0; i < int'(NUM_UNITS); i++) begin
         cand = last_grant + UW'(i) + UW'(1);
         if (!grant_any && valid_vec[cand]) begin
            grant_idx = cand;
            grant_any = 1'b1;
         end
      end
      accept = grant_any && rst_core_n && (state_q == RUN) && !flush_req;
      if (accept) ready_vec = NUM_UNITS'(1) << grant_idx;
      case (state_q)
         RUN:     if (trap_o && !flush_req) state_d = TRAPPED;
         TRAPPED: if (flush_req) state_d = RUN;
         default: state_d = RUN;
      endcase
   end

   // Payload of the granted unit
   always_comb begin
      sel_rd     = alu.rd;
      sel_we     = alu.rd_we;
      sel_trap   = alu.trap;
      sel_result = alu.result;
      sel_pc     = alu.pc;
      case (grant_idx)
         2'd1: begin
            sel_rd = branch.rd; sel_we = branch.rd_we; sel_trap = branch.trap;
            sel_result = branch.result; sel_pc = branch.pc;
         end
         2'd2: begin
            sel_rd = ctrl_status.rd; sel_we = ctrl_status.rd_we; sel_trap = ctrl_status.trap;
            sel_result = ctrl_status.result; sel_pc = ctrl_status.pc;
         end
         2'd3: begin
            sel_rd = mem.rd; sel_we = mem.rd_we; sel_trap = mem.trap;
            sel_result = mem.result; sel_pc = mem.pc;
         end
         default: ;
      endcase
   end

   // A result accepted while the trap pulse is presented is younger than the trap
   assign take   = accept && !trap_o;
   assign sel_wb = sel_we && !sel_trap && (sel_rd != '0);

   // Output register
   always_ff @(posedge clk_core or negedge rst_core_n) begin
      if (!rst_core_n) begin
         wr_en         <= 1'b0;
         wr_addr       <= '0;
         wr_data       <= '0;
         commit_mask   <= '0;
         trap_o        <= 1'b0;
         trap_pc_o     <= '0;
         retired_count <= '0;
      end else if (flush_req) begin
         wr_en       <= 1'b0;
         wr_addr     <= '0;
         wr_data     <= '0;
         commit_mask <= '0;
         trap_o      <= 1'b0;
      end else if (take) begin
         wr_en       <= sel_wb;
         wr_addr     <= sel_rd;
         wr_data     <= sel_result;
         commit_mask <= sel_wb ? (NUM_REGS'(1) << sel_rd) : '0;
         trap_o      <= sel_trap;
         if (sel_trap) trap_pc_o     <= sel_pc;
         else          retired_count <= retired_count + 64'd1;
      end else begin
         wr_en       <= 1'b0;
         commit_mask <= '0;
         trap_o      <= 1'b0;
      end
   end

   // Round-robin pointer, starts so that ALU wins first
   always_ff @(posedge clk_core or negedge rst_core_n) begin
      if (!rst_core_n)  last_grant <= UW'(NUM_UNITS - 1);
      else if (accept)  last_grant <= grant_idx;
   end

   always_ff @(posedge clk_core or negedge rst_core_n) begin
      if (!rst_core_n) flush_ack <= 1'b0;
      else             flush_ack <= flush_req;
   end
endmodule

// File: tb/tb_hsv_core_commit.sv
// Directed bench for hsv_core_commit with hand-computed expectations.
module tb_hsv_core_commit;
   localparam int unsigned XLEN     = 32;
   localparam int unsigned NUM_REGS = 32;
   localparam int unsigned RW       = 5;

   logic                clk_core   = 1'b0;
   logic                rst_core_n = 1'b0;
   logic                flush_req  = 1'b0;
   logic                flush_ack;
   logic [RW-1:0]       wr_addr;
   logic [XLEN-1:0]     wr_data;
   logic                wr_en;
   logic [NUM_REGS-1:0] commit_mask;
   logic                trap_o;
   logic [XLEN-1:0]     trap_pc_o;
   logic [63:0]         retired_count;
   logic [3:0]          rdy;

   int checks = 0;
   int errors = 0;

   hsv_commit_unit_if #(.XLEN(XLEN), .NUM_REGS(NUM_REGS)) alu_if ();
   hsv_commit_unit_if #(.XLEN(XLEN), .NUM_REGS(NUM_REGS)) branch_if ();
   hsv_commit_unit_if #(.XLEN(XLEN), .NUM_REGS(NUM_REGS)) ctrl_status_if ();
   hsv_commit_unit_if #(.XLEN(XLEN), .NUM_REGS(NUM_REGS)) mem_if ();

   hsv_core_commit #(.XLEN(XLEN), .NUM_REGS(NUM_REGS)) dut (
      .clk_core      (clk_core),
      .rst_core_n    (rst_core_n),
      .flush_req     (flush_req),
      .flush_ack     (flush_ack),
      .alu           (alu_if),
      .branch        (branch_if),
      .ctrl_status   (ctrl_status_if),
      .mem           (mem_if),
      .wr_addr       (wr_addr),
      .wr_data       (wr_data),
      .wr_en         (wr_en),
      .commit_mask   (commit_mask),
      .trap_o        (trap_o),
      .trap_pc_o     (trap_pc_o),
      .retired_count (retired_count)
   );

   always #5 clk_core = ~clk_core;

   assign rdy = {mem_if.ready_o, ctrl_status_if.ready_o, branch_if.ready_o, alu_if.ready_o};

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic set_unit(input int u, input logic v, input logic [RW-1:0] rd, input logic we,
                           input logic [XLEN-1:0] res, input logic trap, input logic [XLEN-1:0] pc);
      case (u)
         0: begin alu_if.valid_i = v; alu_if.rd = rd; alu_if.rd_we = we;
                  alu_if.result = res; alu_if.trap = trap; alu_if.pc = pc; end
         1: begin branch_if.valid_i = v; branch_if.rd = rd; branch_if.rd_we = we;
                  branch_if.result = res; branch_if.trap = trap; branch_if.pc = pc; end
         2: begin ctrl_status_if.valid_i = v; ctrl_status_if.rd = rd; ctrl_status_if.rd_we = we;
                  ctrl_status_if.result = res; ctrl_status_if.trap = trap; ctrl_status_if.pc = pc; end
         default: begin mem_if.valid_i = v; mem_if.rd = rd; mem_if.rd_we = we;
                  mem_if.result = res; mem_if.trap = trap; mem_if.pc = pc; end
      endcase
   endtask

   task automatic idle_all();
      for (int u = 0; u < 4; u++) set_unit(u, 1'b0, '0, 1'b0, '0, 1'b0, '0);
   endtask

   task automatic cyc();
      @(posedge clk_core);
      #1;
   endtask

   initial begin
      int gi;
      int pi;
      idle_all();
      set_unit(0, 1'b1, 5'd3, 1'b1, 32'h1, 1'b0, 32'h0);
      #2;
      // Reset state, ready must stay low even with a valid ALU
      check("rst_ready",   64'(rdy), 64'h0);
      check("rst_wr_en",   64'(wr_en), 64'h0);
      check("rst_wr_addr", 64'(wr_addr), 64'h0);
      check("rst_wr_data", 64'(wr_data), 64'h0);
      check("rst_mask",    64'(commit_mask), 64'h0);
      check("rst_trap",    64'(trap_o), 64'h0);
      check("rst_trap_pc", 64'(trap_pc_o), 64'h0);
      check("rst_count",   retired_count, 64'h0);
      check("rst_fack",    64'(flush_ack), 64'h0);
      cyc();
      cyc();

      // Single ALU commit
      rst_core_n = 1'b1;
      set_unit(0, 1'b1, 5'd5, 1'b1, 32'hDEADBEEF, 1'b0, 32'h1000);
      #1;
      check("t1_ready", 64'(rdy), 64'h1);
      cyc();
      idle_all();
      #1;
      check("t1_wr_en",   64'(wr_en), 64'h1);
      check("t1_wr_addr", 64'(wr_addr), 64'h5);
      check("t1_wr_data", 64'(wr_data), 64'hDEADBEEF);
      check("t1_mask",    64'(commit_mask), 64'h20);
      check("t1_count",   retired_count, 64'd1);

      // x0 destination: counted, not written
      cyc();
      set_unit(0, 1'b1, 5'd0, 1'b1, 32'h1234, 1'b0, 32'h1004);
      #1;
      check("x0_ready", 64'(rdy), 64'h1);
      cyc();
      idle_all();
      set_unit(3, 1'b1, 5'd9, 1'b0, 32'h99, 1'b0, 32'h1008);
      #1;
      check("x0_wr_en", 64'(wr_en), 64'h0);
      check("x0_mask",  64'(commit_mask), 64'h0);
      check("x0_count", retired_count, 64'd2);
      check("nw_ready", 64'(rdy), 64'h8);
      cyc();
      idle_all();
      #1;
      check("nw_wr_en", 64'(wr_en), 64'h0);
      check("nw_mask",  64'(commit_mask), 64'h0);
      check("nw_count", retired_count, 64'd3);

      // Round-robin, all four valid, pointer now at mem
      cyc();
      for (int u = 0; u < 4; u++)
         set_unit(u, 1'b1, 5'(u + 1), 1'b1, 32'h1000_0000 + 32'(u), 1'b0, 32'h2000);
      for (int k = 0; k < 8; k++) begin
         #1;
         gi = k % 4;
         check($sformatf("rr%0d_ready", k), 64'(rdy), 64'(1) << gi);
         if (k > 0) begin
            pi = (k - 1) % 4;
            check($sformatf("rr%0d_wr_en", k), 64'(wr_en), 64'h1);
            check($sformatf("rr%0d_mask", k), 64'(commit_mask), 64'(1) << (pi + 1));
         end
         @(posedge clk_core);
         #1;
      end
      idle_all();
      #1;
      check("rr_last_mask", 64'(commit_mask), 64'h10);
      check("rr_last_data", 64'(wr_data), 64'h1000_0003);
      check("rr_count",     retired_count, 64'd11);

      // Mem trap while ALU is also valid
      cyc();
      set_unit(0, 1'b1, 5'd6, 1'b1, 32'h66, 1'b0, 32'h3000);
      set_unit(3, 1'b1, 5'd7, 1'b1, 32'h77, 1'b1, 32'h80000040);
      #1;
      check("tr_alu_first", 64'(rdy), 64'h1);
      cyc();
      #1;
      check("tr_mem_grant", 64'(rdy), 64'h8);
      check("tr_alu_wr",    64'(wr_addr), 64'h6);
      check("tr_count0",    retired_count, 64'd12);
      cyc();
      set_unit(3, 1'b0, '0, 1'b0, '0, 1'b0, '0);
      #1;
      check("tr_pulse",   64'(trap_o), 64'h1);
      check("tr_pc",      64'(trap_pc_o), 64'h80000040);
      check("tr_wr_en",   64'(wr_en), 64'h0);
      check("tr_mask",    64'(commit_mask), 64'h0);
      check("tr_disc_rd", 64'(rdy), 64'h1);
      cyc();
      #1;
      check("tr_pulse_end", 64'(trap_o), 64'h0);
      check("tr_disc_wr",   64'(wr_en), 64'h0);
      check("tr_disc_mask", 64'(commit_mask), 64'h0);
      check("tr_disc_cnt",  retired_count, 64'd12);
      check("tr_blocked0",  64'(rdy), 64'h0);
      check("tr_pc_hold",   64'(trap_pc_o), 64'h80000040);
      cyc();
      #1;
      check("tr_blocked1", 64'(rdy), 64'h0);
      cyc();
      flush_req = 1'b1;
      #1;
      check("tr_flush_rdy", 64'(rdy), 64'h0);
      check("tr_fack_lo",   64'(flush_ack), 64'h0);
      cyc();
      flush_req = 1'b0;
      #1;
      check("tr_fack_hi", 64'(flush_ack), 64'h1);
      check("tr_alu_back", 64'(rdy), 64'h1);
      cyc();
      idle_all();
      #1;
      check("tr_fack_end", 64'(flush_ack), 64'h0);
      check("tr_post_wr",  64'(wr_en), 64'h1);
      check("tr_post_rd",  64'(wr_addr), 64'h6);
      check("tr_post_cnt", retired_count, 64'd13);

      // Flush alongside a valid branch result
      cyc();
      set_unit(0, 1'b1, 5'd11, 1'b1, 32'hB0B, 1'b0, 32'h4000);
      #1;
      check("fl_alu_rdy", 64'(rdy), 64'h1);
      cyc();
      set_unit(0, 1'b0, '0, 1'b0, '0, 1'b0, '0);
      set_unit(1, 1'b1, 5'd10, 1'b1, 32'hA0A, 1'b0, 32'h4004);
      flush_req = 1'b1;
      #1;
      check("fl_br_rdy",  64'(rdy), 64'h0);
      check("fl_old_wr",  64'(wr_en), 64'h1);
      check("fl_old_msk", 64'(commit_mask), 64'h800);
      cyc();
      flush_req = 1'b0;
      set_unit(0, 1'b1, 5'd12, 1'b1, 32'hC0C, 1'b0, 32'h4008);
      #1;
      check("fl_clr_wr",   64'(wr_en), 64'h0);
      check("fl_clr_msk",  64'(commit_mask), 64'h0);
      check("fl_clr_addr", 64'(wr_addr), 64'h0);
      check("fl_clr_data", 64'(wr_data), 64'h0);
      check("fl_fack",     64'(flush_ack), 64'h1);
      check("fl_count",    retired_count, 64'd14);
      check("fl_lg_kept",  64'(rdy), 64'h2);
      cyc();
      idle_all();
      #1;
      check("fl_br_wr",   64'(wr_en), 64'h1);
      check("fl_br_addr", 64'(wr_addr), 64'hA);
      check("fl_br_data", 64'(wr_data), 64'hA0A);
      check("fl_br_mask", 64'(commit_mask), 64'h400);
      check("fl_br_cnt",  retired_count, 64'd15);

      // Asynchronous reset while a write is presented
      #2;
      set_unit(0, 1'b1, 5'd3, 1'b1, 32'h3, 1'b0, 32'h0);
      rst_core_n = 1'b0;
      #1;
      check("ar_wr_en",   64'(wr_en), 64'h0);
      check("ar_mask",    64'(commit_mask), 64'h0);
      check("ar_addr",    64'(wr_addr), 64'h0);
      check("ar_data",    64'(wr_data), 64'h0);
      check("ar_count",   retired_count, 64'h0);
      check("ar_trap_pc", 64'(trap_pc_o), 64'h0);
      check("ar_ready",   64'(rdy), 64'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
